btb_update_ctrl: RTL and testbench

Update scheduler for the branch target buffer table. It captures branch-resolution events from execute into a small FIFO and owns per-index 2-bit saturating counters. It serialises counter/target writes onto the table's single write port and sequences a full-table invalidate sweep on `fence.i`. It sits between the execute-stage resolution logic and the BTB storage array.

---
 rtl/btb_update_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//   Update scheduler for the branch target buffer. Branch-resolution events are
//   captured in a small FIFO, the per-index 2-bit saturating counters live here,
//   and counter/target writes are serialised onto the table's single write port.
//   A fence.i flush request sequences an invalidate sweep over every entry.
//
//   Optional feature: define BTB_UPD_STATS_EN to add the drop/update counters.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     hold_i            pipeline hold, resolution events ignored while high
//     res_valid_i       resolution event valid
//     res_pc_i          PC of the resolved branch/jump
//     res_target_i      computed target
//     res_taken_i       actual direction
//     flush_req_i       invalidate-all request (single-cycle pulse)
//     wr_ready_i        table write port free this cycle
//     wr_en_o           table write strobe
//     wr_idx_o          write index
//     wr_tag_o          tag = pc[ADDR_W-1:IDX_W+2]
//     wr_target_o       target to store
//     wr_valid_o        entry valid bit to store
//     wr_ctr_o          new counter value
//     flush_done_o      one-cycle pulse on the last accepted sweep write
//     busy_o            FIFO non-empty, flush pending or not idle
//     overflow_o        sticky, an event was dropped on a full FIFO
//     drop_cnt_o        (BTB_UPD_STATS_EN) saturating count of dropped events
//     upd_cnt_o         (BTB_UPD_STATS_EN) wrapping count of accepted updates
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned IDX_W      = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hold_i,
   input  logic                      res_valid_i,
   input  logic [ADDR_W-1:0]         res_pc_i,
   input  logic [ADDR_W-1:0]         res_target_i,
   input  logic                      res_taken_i,
   input  logic                      flush_req_i,
   input  logic                      wr_ready_i,
   output logic                      wr_en_o,
   output logic [IDX_W-1:0]          wr_idx_o,
   output logic [ADDR_W-IDX_W-3:0]   wr_tag_o,
   output logic [ADDR_W-1:0]         wr_target_o,
   output logic                      wr_valid_o,
   output logic [1:0]                wr_ctr_o,
   output logic                      flush_done_o,
   output logic                      busy_o,
   output logic                      overflow_o
`ifdef BTB_UPD_STATS_EN
   ,
   output logic [15:0]               drop_cnt_o,
   output logic [15:0]               upd_cnt_o
`endif
);

   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned PCS_W   = ADDR_W - 2;
   localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_UPD   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam logic [1:0] CTR_INIT = 2'b01;

   // state
   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_flush_pend;
   logic [IDX_W-1:0]  r_sweep;
   logic              r_overflow;

   // resolution FIFO; the word-aligned low PC bits are never needed
   logic [PCS_W-1:0]  r_fifo_pc  [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fifo_tgt [FIFO_DEPTH];
   logic              r_fifo_tkn [FIFO_DEPTH];
   logic [CNT_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  w_count;
   logic              w_empty;
   logic              w_full;

   // counter array
   logic [1:0]        r_ctr [ENTRIES];

   // head-of-FIFO view
   logic [PCS_W-1:0]  w_head_pc;
   logic [ADDR_W-1:0] w_head_tgt;
   logic              w_head_tkn;
   logic [IDX_W-1:0]  w_head_idx;
   logic [TAG_W-1:0]  w_head_tag;
   logic [1:0]        w_cur_ctr;
   logic [1:0]        w_upd_ctr;

   // handshakes
   logic              w_enq_req;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic              w_sweep_adv;
   logic              w_sweep_last;
   logic              w_flush_enter;
   logic              w_unused;

   assign w_unused = &{1'b0, res_pc_i[1:0]};

   // FIFO occupancy
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

   // head entry and its counter update
   assign w_head_pc  = r_fifo_pc[r_rd_ptr[PTR_W-1:0]];
   assign w_head_tgt = r_fifo_tgt[r_rd_ptr[PTR_W-1:0]];
   assign w_head_tkn = r_fifo_tkn[r_rd_ptr[PTR_W-1:0]];
   assign w_head_idx = w_head_pc[IDX_W-1:0];
   assign w_head_tag = w_head_pc[PCS_W-1:IDX_W];
   assign w_cur_ctr  = r_ctr[w_head_idx];

   always_comb begin
      if (w_head_tkn) begin
         w_upd_ctr = (w_cur_ctr == 2'b11) ? 2'b11 : (w_cur_ctr + 2'b01);
      end else begin
         w_upd_ctr = (w_cur_ctr == 2'b00) ? 2'b00 : (w_cur_ctr - 2'b01);
      end
   end

   // write-port handshakes; kept outside the FSM block so the push path
   // (which feeds next-state) has no loop back through it
   assign w_pop        = (r_state == S_UPD) && wr_ready_i;
   assign w_sweep_adv  = (r_state == S_FLUSH) && wr_ready_i;
   assign w_sweep_last = (r_sweep == {IDX_W{1'b1}});

   // events are refused while a flush is pending or sweeping; a full FIFO
   // still accepts when the head pops in the same cycle
   assign w_enq_req = res_valid_i && !hold_i && (r_state != S_FLUSH) && !r_flush_pend;
   assign w_push    = w_enq_req && (!w_full || w_pop);
   assign w_drop    = w_enq_req && w_full && !w_pop;

   assign w_flush_enter = (r_state != S_FLUSH) && (w_state_nxt == S_FLUSH);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state and write-port outputs
   always_comb begin
      w_state_nxt  = r_state;
      wr_en_o      = 1'b0;
      wr_idx_o     = '0;
      wr_tag_o     = '0;
      wr_target_o  = '0;
      wr_valid_o   = 1'b0;
      wr_ctr_o     = 2'b00;
      flush_done_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_flush_pend) begin
               w_state_nxt = S_FLUSH;
            end else if (!w_empty) begin
               w_state_nxt = S_UPD;
            end
         end
         S_UPD: begin
            wr_en_o     = 1'b1;
            wr_idx_o    = w_head_idx;
            wr_tag_o    = w_head_tag;
            wr_target_o = w_head_tgt;
            wr_ctr_o    = w_upd_ctr;
            wr_valid_o  = w_head_tkn | w_upd_ctr[1];
            if (wr_ready_i) begin
               if (r_flush_pend) begin
                  w_state_nxt = S_FLUSH;
               end else if ((w_count == CNT_W'(1)) && !w_push) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            wr_en_o  = 1'b1;
            wr_idx_o = r_sweep;
            wr_ctr_o = CTR_INIT;
            if (wr_ready_i && w_sweep_last) begin
               flush_done_o = 1'b1;
               w_state_nxt  = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy_o     = !w_empty || r_flush_pend || (r_state != S_IDLE);
   assign overflow_o = r_overflow;

   // FIFO pointers; entering the sweep discards everything still queued
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush_enter) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + CNT_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + CNT_W'(1);
         end
      end
   end

   // FIFO storage; contents are only observed through valid pointers
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr[PTR_W-1:0]]  <= res_pc_i[ADDR_W-1:2];
         r_fifo_tgt[r_wr_ptr[PTR_W-1:0]] <= res_target_i;
         r_fifo_tkn[r_wr_ptr[PTR_W-1:0]] <= res_taken_i;
      end
   end

   // counters commit only when the table accepts the write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= CTR_INIT;
         end
      end else if (w_pop) begin
         r_ctr[w_head_idx] <= w_upd_ctr;
      end else if (w_sweep_adv) begin
         r_ctr[r_sweep] <= CTR_INIT;
      end
   end

   // sweep pointer wraps back to zero after the last index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sweep <= '0;
      end else if (w_sweep_adv) begin
         r_sweep <= r_sweep + IDX_W'(1);
      end
   end

   // flush pending; requests during a sweep are ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_pend <= 1'b0;
      end else if (flush_done_o) begin
         r_flush_pend <= 1'b0;
      end else if (flush_req_i && (r_state != S_FLUSH)) begin
         r_flush_pend <= 1'b1;
      end
   end

   // sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

`ifdef BTB_UPD_STATS_EN
   logic [15:0] r_drop_cnt;
   logic [15:0] r_upd_cnt;

   // drop counter saturates, update counter wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
         r_upd_cnt  <= '0;
      end else begin
         if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
         if (w_pop) begin
            r_upd_cnt <= r_upd_cnt + 16'd1;
         end
      end
   end

   assign drop_cnt_o = r_drop_cnt;
   assign upd_cnt_o  = r_upd_cnt;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
`timescale 1ns/1ps
module tb_btb_update_ctrl;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned ENTRIES    = 16;
   localparam int unsigned TAG_W      = ADDR_W - IDX_W - 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               hold_i;
   logic               res_valid_i;
   logic [ADDR_W-1:0]  res_pc_i;
   logic [ADDR_W-1:0]  res_target_i;
   logic               res_taken_i;
   logic               flush_req_i;
   logic               wr_ready_i;
   logic               wr_en_o;
   logic [IDX_W-1:0]   wr_idx_o;
   logic [TAG_W-1:0]   wr_tag_o;
   logic [ADDR_W-1:0]  wr_target_o;
   logic               wr_valid_o;
   logic [1:0]         wr_ctr_o;
   logic               flush_done_o;
   logic               busy_o;
   logic               overflow_o;
`ifdef BTB_UPD_STATS_EN
   logic [15:0]        drop_cnt_o;
   logic [15:0]        upd_cnt_o;
`endif

   always #5 clk = ~clk;

   btb_update_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .hold_i(hold_i), .res_valid_i(res_valid_i),
      .res_pc_i(res_pc_i), .res_target_i(res_target_i), .res_taken_i(res_taken_i),
      .flush_req_i(flush_req_i), .wr_ready_i(wr_ready_i), .wr_en_o(wr_en_o),
      .wr_idx_o(wr_idx_o), .wr_tag_o(wr_tag_o), .wr_target_o(wr_target_o),
      .wr_valid_o(wr_valid_o), .wr_ctr_o(wr_ctr_o), .flush_done_o(flush_done_o),
      .busy_o(busy_o), .overflow_o(overflow_o)
`ifdef BTB_UPD_STATS_EN
      , .drop_cnt_o(drop_cnt_o), .upd_cnt_o(upd_cnt_o)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // behavioural model: pending events, counters, flush bookkeeping
   logic [31:0] m_pc  [$];
   logic [31:0] m_tgt [$];
   bit          m_tkn [$];
   int          m_ctr [ENTRIES];
   bit          m_pend, m_sweeping, m_ovf;
   int          m_sweep, m_drop, m_upd, m_wait;

   // log of accepted writes for the directed checks
   int log_idx [$];
   int log_ctr [$];
   int log_val [$];
   int done_cnt = 0;

   task automatic model_reset();
      m_pc.delete(); m_tgt.delete(); m_tkn.delete();
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
      m_pend = 0; m_sweeping = 0; m_ovf = 0;
      m_sweep = 0; m_drop = 0; m_upd = 0; m_wait = 0;
   endtask

   task automatic log_clear();
      log_idx.delete(); log_ctr.delete(); log_val.delete();
   endtask

   // compare process: outputs checked mid-cycle, then the model advances
   // across the coming edge
   always @(negedge clk) begin
      bit pre_sweep, pre_pend, pop, enq_req;
      int pre_size, idx, cur, nxt;
      if (rst) begin
         model_reset();
      end else begin
         pre_sweep = m_sweeping;
         pre_pend  = m_pend;
         pre_size  = m_pc.size();
         pop       = 0;
         chk("busy", busy_o, (pre_size > 0) || pre_pend || pre_sweep);
         chk("overflow", overflow_o, m_ovf);
`ifdef BTB_UPD_STATS_EN
         chk("drop_cnt", drop_cnt_o, m_drop);
         chk("upd_cnt", upd_cnt_o, m_upd);
`endif
         if (flush_done_o) done_cnt++;
         if (!wr_en_o) begin
            chk("flush_done_idle", flush_done_o, 0);
            if (pre_pend && !pre_sweep) begin
               m_pc.delete(); m_tgt.delete(); m_tkn.delete();
               m_sweeping = 1; m_sweep = 0; m_wait = 0;
            end else if (pre_size > 0) begin
               m_wait++;
               chk("upd_start_latency", m_wait <= 1, 1);
            end else begin
               m_wait = 0;
            end
         end else if (pre_sweep) begin
            m_wait = 0;
            chk("sweep_idx", wr_idx_o, m_sweep);
            chk("sweep_valid", wr_valid_o, 0);
            chk("sweep_ctr", wr_ctr_o, 1);
            chk("sweep_tag", wr_tag_o, 0);
            chk("sweep_target", wr_target_o, 0);
            chk("sweep_done", flush_done_o, wr_ready_i && (m_sweep == ENTRIES - 1));
            if (wr_ready_i) begin
               log_idx.push_back(int'(wr_idx_o)); log_ctr.push_back(int'(wr_ctr_o));
               log_val.push_back(int'(wr_valid_o));
               m_ctr[m_sweep] = 1;
               if (m_sweep == ENTRIES - 1) begin
                  m_sweeping = 0; m_pend = 0; m_sweep = 0;
               end else begin
                  m_sweep++;
               end
            end
         end else if (pre_size > 0) begin
            m_wait = 0;
            idx = int'(m_pc[0][5:2]);
            cur = m_ctr[idx];
            nxt = m_tkn[0] ? ((cur < 3) ? cur + 1 : 3) : ((cur > 0) ? cur - 1 : 0);
            chk("upd_idx", wr_idx_o, idx);
            chk("upd_tag", wr_tag_o, m_pc[0][31:6]);
            chk("upd_target", wr_target_o, m_tgt[0]);
            chk("upd_ctr", wr_ctr_o, nxt);
            chk("upd_valid", wr_valid_o, m_tkn[0] || (nxt >= 2));
            chk("upd_flush_done", flush_done_o, 0);
            if (wr_ready_i) begin
               pop = 1;
               log_idx.push_back(idx); log_ctr.push_back(int'(wr_ctr_o));
               log_val.push_back(int'(wr_valid_o));
               m_ctr[idx] = nxt;
               void'(m_pc.pop_front()); void'(m_tgt.pop_front()); void'(m_tkn.pop_front());
               m_upd = (m_upd + 1) & 16'hFFFF;
               if (pre_pend) begin
                  m_pc.delete(); m_tgt.delete(); m_tkn.delete();
                  m_sweeping = 1; m_sweep = 0;
               end
            end
         end else begin
            chk("spurious_wr_en", wr_en_o, 0);
         end
         enq_req = res_valid_i && !hold_i && !pre_sweep && !pre_pend;
         if (enq_req) begin
            if ((pre_size < FIFO_DEPTH) || pop) begin
               m_pc.push_back(res_pc_i); m_tgt.push_back(res_target_i);
               m_tkn.push_back(res_taken_i);
            end else begin
               m_ovf = 1;
               if (m_drop < 65535) m_drop++;
            end
         end
         if (flush_req_i && !pre_sweep) m_pend = 1;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input bit tkn);
      res_pc_i = pc; res_target_i = tgt; res_taken_i = tkn; res_valid_i = 1'b1;
      step(1);
      res_valid_i = 1'b0;
   endtask

   task automatic pulse_flush();
      flush_req_i = 1'b1;
      step(1);
      flush_req_i = 1'b0;
   endtask

   initial begin
      int exp_ctr [5];
      int exp_val [5];
      exp_ctr = '{2, 3, 3, 2, 1};
      exp_val = '{1, 1, 1, 1, 0};
      rst = 1'b1; hold_i = 1'b0; res_valid_i = 1'b0; res_pc_i = '0; res_target_i = '0;
      res_taken_i = 1'b0; flush_req_i = 1'b0; wr_ready_i = 1'b0;
      step(3);
      rst = 1'b0;

      // reset values
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_flush_done", flush_done_o, 0);
      chk("rst_wr_data", {wr_idx_o, wr_tag_o, wr_target_o, wr_valid_o, wr_ctr_o}, 0);

      // single taken event, two-cycle latency to the write
      wr_ready_i = 1'b1;
      send(32'h8000_0010, 32'h8000_0100, 1'b1);
      chk("t1_not_yet", wr_en_o, 0);
      chk("t1_busy", busy_o, 1);
      step(1);
      chk("t1_wr_en", wr_en_o, 1);
      chk("t1_idx", wr_idx_o, 4);
      chk("t1_ctr", wr_ctr_o, 2'b10);
      chk("t1_valid", wr_valid_o, 1);
      chk("t1_target", wr_target_o, 32'h8000_0100);
      chk("t1_tag", wr_tag_o, 26'h200_0000);
      step(3);
      chk("t1_idle", busy_o, 0);

      // counter saturation on one index, back-to-back writes
      log_clear();
      send(32'h8000_0020, 32'h1000, 1'b1);
      send(32'h8000_0020, 32'h1000, 1'b1);
      send(32'h8000_0020, 32'h1000, 1'b1);
      send(32'h8000_0020, 32'h1000, 1'b0);
      send(32'h8000_0020, 32'h1000, 1'b0);
      step(6);
      chk("t2_count", log_ctr.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t2_ctr%0d", i), (i < log_ctr.size()) ? log_ctr[i] : -1, exp_ctr[i]);
         chk($sformatf("t2_val%0d", i), (i < log_val.size()) ? log_val[i] : -1, exp_val[i]);
      end

      // overflow: five events into a stalled four-deep FIFO
      wr_ready_i = 1'b0;
      log_clear();
      for (int i = 0; i < 5; i++) send(32'h8000_0030 + 32'(4 * i), 32'(i), 1'b1);
      chk("t3_overflow", overflow_o, 1);
      chk("t3_stalled_wr_en", wr_en_o, 1);
`ifdef BTB_UPD_STATS_EN
      chk("t3_drop_cnt", drop_cnt_o, 1);
`endif
      wr_ready_i = 1'b1;
      step(8);
      chk("t3_drained", log_idx.size(), 4);
      chk("t3_first_idx", (log_idx.size() > 0) ? log_idx[0] : -1, 12);
      chk("t3_last_idx", (log_idx.size() > 3) ? log_idx[3] : -1, 15);
      chk("t3_overflow_sticky", overflow_o, 1);

      // flush while an update is stalled in UPD
      wr_ready_i = 1'b0;
      log_clear();
      send(32'h8000_0040, 32'h2000, 1'b1);
      send(32'h8000_0044, 32'h2004, 1'b0);
      step(1);
      chk("t4_in_upd", wr_en_o, 1);
      pulse_flush();
      wr_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (done_cnt != 0) break;
      end
      chk("t4_done_seen", done_cnt, 1);
      chk("t4_writes", log_idx.size(), 17);
      chk("t4_first_upd_ctr", (log_ctr.size() > 0) ? log_ctr[0] : -1, 2);
      chk("t4_sweep_first", (log_idx.size() > 1) ? log_idx[1] : -1, 0);
      chk("t4_sweep_last", (log_idx.size() > 16) ? log_idx[16] : -1, 15);
      chk("t4_idle_after", busy_o, 0);
      log_clear();
      send(32'h8000_0010, 32'h8000_0100, 1'b1);
      step(3);
      chk("t4_post_flush_ctr", (log_ctr.size() > 0) ? log_ctr[0] : -1, 2);

      // held events are ignored
      log_clear();
      hold_i = 1'b1;
      send(32'h8000_0050, 32'h3000, 1'b1);
      chk("t5_busy_hold", busy_o, 0);
      hold_i = 1'b0;
      step(3);
      chk("t5_no_write", log_idx.size(), 0);

      // reset mid-sweep aborts it; idx 4 was 10 and must be back at 01
      pulse_flush();
      for (int i = 0; i < 30; i++) begin
         if (wr_en_o && (wr_idx_o == 4'd7)) break;
         step(1);
      end
      chk("t6_at_idx7", {wr_en_o, wr_idx_o}, {1'b1, 4'd7});
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("t6_busy", busy_o, 0);
      chk("t6_wr_en", wr_en_o, 0);
      chk("t6_no_done", done_cnt, 1);
      chk("t6_overflow_cleared", overflow_o, 0);
      log_clear();
      send(32'h8000_0010, 32'h8000_0100, 1'b1);
      step(3);
      chk("t6_ctr_reset", (log_ctr.size() > 0) ? log_ctr[0] : -1, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL global_timeout: got running expected finished");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
